hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 16 +
 rtl/load_scoreboard.sv | 60 ++++++
 rtl/hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_hazard_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: FSM encodings and the
// helper that sizes the small down-counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_JUMP_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register pending-load counters and the load-use hazard compare.
// A counter holds the number of further cycles a load result is still
// unavailable after the load has left EX; the EX load itself is caught by
// a direct address compare.
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam int CW   = cnt_width(LOAD_LAT);
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT - 1);

  logic [CW-1:0] pend [NREG];
  logic          ex_load;
  logic          rs_hit;
  logic          rt_hit;

  // Writes to r0 are discarded, so a load to r0 never creates a hazard.
  assign ex_load = ex_valid && ex_is_load && (ex_rt != '0);

  // Pending counters: a fresh load wins over the decrement of its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ex_load && (ex_rt == REG_ADDR_W'(i))) begin
          pend[i] <= LOAD_INIT;
        end else if (pend[i] != '0) begin
          pend[i] <= pend[i] - CW'(1);
        end
      end
    end
  end

  // Hazard compare on the source registers the ID instruction really reads.
  always_comb begin
    rs_hit = (id_rs != '0) && ((ex_load && (ex_rt == id_rs)) || (pend[id_rs] != '0));
    rt_hit = (id_rt != '0) && ((ex_load && (ex_rt == id_rt)) || (pend[id_rt] != '0));
    hazard = id_valid && (rs_hit || (id_uses_rt && rt_hit));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use stalls from the scoreboard, fixed-length
// branch/jump stalls, and a sticky halt that only flush or reset clears.
// o_stall holds PC and IF/ID; o_bubble injects a NOP into ID/EX. Both are
// combinational so a hazard is acted on in the cycle it is seen.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int JUMP_STALL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_is_jump,
  input  logic                  i_id_is_halt,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  output logic                  o_stall,
  output logic                  o_bubble,
  output logic                  o_halt,
  output logic [1:0]            o_state
);

  localparam int JW = cnt_width(JUMP_STALL);
  localparam logic [JW-1:0] JUMP_INIT = JW'(JUMP_STALL - 1);

  state_e        state;
  logic [JW-1:0] jump_cnt;
  logic          halt_q;
  logic          hazard;
  logic          busy;
  logic          active;

  load_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) u_load_sb (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_flush),
    .id_valid   (i_id_valid),
    .id_rs      (i_id_rs),
    .id_rt      (i_id_rt),
    .id_uses_rt (i_id_uses_rt),
    .ex_valid   (i_ex_valid),
    .ex_is_load (i_ex_is_load),
    .ex_rt      (i_ex_rt),
    .hazard     (hazard)
  );

  // Whether the ID instruction must be held this cycle, by state.
  always_comb begin
    busy = 1'b0;
    case (state)
      ST_RUN:       busy = hazard || (i_id_valid && i_id_is_jump);
      ST_JUMP_WAIT: busy = hazard || (jump_cnt != '0);
      ST_HALTED:    busy = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  // Halted holds regardless of ID; otherwise nothing stalls without a valid
  // ID instruction. Reset masks the combinational EX compare immediately.
  assign active   = (state == ST_HALTED) || (i_id_valid && busy);
  assign o_stall  = i_rst_n && active;
  assign o_bubble = i_rst_n && active;
  assign o_halt   = halt_q;
  assign o_state  = state;

  // Control FSM: load hazard beats jump, jump beats halt; flush beats all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_RUN;
      jump_cnt <= '0;
      halt_q   <= 1'b0;
    end else if (i_flush) begin
      state    <= ST_RUN;
      jump_cnt <= '0;
      halt_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!hazard) begin
            if (i_id_valid && i_id_is_jump) begin
              jump_cnt <= JUMP_INIT;
              state    <= ST_JUMP_WAIT;
            end else if (i_id_valid && i_id_is_halt) begin
              state  <= ST_HALTED;
              halt_q <= 1'b1;
            end
          end
        end
        ST_JUMP_WAIT: begin
          // A load hazard freezes the jump countdown. Leaving on zero does
          // not look at i_id_is_jump, so the held jump is not re-taken.
          if (!hazard) begin
            if (jump_cnt != '0) jump_cnt <= jump_cnt - JW'(1);
            else                state    <= ST_RUN;
          end
        end
        ST_HALTED: begin
          halt_q <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          jump_cnt <= '0;
          halt_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances share one stimulus stream,
// dut_a with LOAD_LAT=1/JUMP_STALL=1 and dut_b with LOAD_LAT=3/JUMP_STALL=2.
module tb_hazard_scoreboard;

  localparam int RW = 5;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_id_valid;
  logic [RW-1:0] i_id_rs;
  logic [RW-1:0] i_id_rt;
  logic          i_id_uses_rt;
  logic          i_id_is_jump;
  logic          i_id_is_halt;
  logic          i_ex_valid;
  logic          i_ex_is_load;
  logic [RW-1:0] i_ex_rt;

  logic       stall_a, bubble_a, halt_a;
  logic [1:0] state_a;
  logic       stall_b, bubble_b, halt_b;
  logic [1:0] state_b;

  hazard_scoreboard #(.REG_ADDR_W(RW), .LOAD_LAT(1), .JUMP_STALL(1)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rt(i_id_uses_rt), .i_id_is_jump(i_id_is_jump), .i_id_is_halt(i_id_is_halt),
    .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rt(i_ex_rt),
    .o_stall(stall_a), .o_bubble(bubble_a), .o_halt(halt_a), .o_state(state_a)
  );

  hazard_scoreboard #(.REG_ADDR_W(RW), .LOAD_LAT(3), .JUMP_STALL(2)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rt(i_id_uses_rt), .i_id_is_jump(i_id_is_jump), .i_id_is_halt(i_id_is_halt),
    .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rt(i_ex_rt),
    .o_stall(stall_b), .o_bubble(bubble_b), .o_halt(halt_b), .o_state(state_b)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A load in EX at cycle t makes its register unreadable for cycles
  // t .. t+LOAD_LAT-1; the model keeps the first cycle it is readable again.
  int ll[2];
  int js[2];
  int ready_at[2][32];
  int mode[2];   // 0 run, 1 waiting out a jump, 2 halted
  int jleft[2];  // jump stall cycles still owed after the first one
  int cyc = 0;

  function automatic bit m_hit(input int k, input int r);
    return (r != 0) && ((i_ex_valid && i_ex_is_load && (int'(i_ex_rt) == r)) ||
                        (cyc < ready_at[k][r]));
  endfunction

  function automatic bit m_hazard(input int k);
    return i_id_valid && (m_hit(k, int'(i_id_rs)) || (i_id_uses_rt && m_hit(k, int'(i_id_rt))));
  endfunction

  function automatic bit m_stall(input int k);
    if (mode[k] == 2) return 1'b1;
    if (!i_id_valid) return 1'b0;
    if (m_hazard(k)) return 1'b1;
    if (mode[k] == 0) return i_id_is_jump;
    return jleft[k] > 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
      mode[k]  = 0;
      jleft[k] = 0;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit hz;
      hz = m_hazard(k);
      if (i_flush) begin
        for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
        mode[k]  = 0;
        jleft[k] = 0;
      end else begin
        if (i_ex_valid && i_ex_is_load && i_ex_rt != 0) ready_at[k][int'(i_ex_rt)] = cyc + ll[k];
        if (mode[k] == 0 && !hz) begin
          if (i_id_valid && i_id_is_jump) begin
            jleft[k] = js[k] - 1;
            mode[k]  = 1;
          end else if (i_id_valid && i_id_is_halt) begin
            mode[k] = 2;
          end
        end else if (mode[k] == 1 && !hz) begin
          if (jleft[k] > 0) jleft[k]--;
          else mode[k] = 0;
        end
      end
    end
    cyc++;
  endtask

  function automatic int out_of(input int k, input int which);
    case (which)
      0: return k ? int'(stall_b)  : int'(stall_a);
      1: return k ? int'(bubble_b) : int'(bubble_a);
      2: return k ? int'(state_b)  : int'(state_a);
      default: return k ? int'(halt_b) : int'(halt_a);
    endcase
  endfunction

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      string nm;
      nm = $sformatf("%s/%s", tag, k ? "b" : "a");
      chk({nm, " stall"},  out_of(k, 0), int'(m_stall(k)));
      chk({nm, " bubble"}, out_of(k, 1), int'(m_stall(k)));
      chk({nm, " state"},  out_of(k, 2), mode[k]);
      chk({nm, " halt"},   out_of(k, 3), int'(mode[k] == 2));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit idv, input int rs, input int rt, input bit urt,
                       input bit jmp, input bit hlt, input bit exv, input bit exl,
                       input int exrt, input bit fl);
    i_id_valid   = idv;
    i_id_rs      = RW'(rs);
    i_id_rt      = RW'(rt);
    i_id_uses_rt = urt;
    i_id_is_jump = jmp;
    i_id_is_halt = hlt;
    i_ex_valid   = exv;
    i_ex_is_load = exl;
    i_ex_rt      = RW'(exrt);
    i_flush      = fl;
  endtask

  task automatic advance();
    @(posedge i_clk);
    model_clock();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit idv; int rs; int rt; bit urt; bit jmp; bit hlt;
    bit exv; bit exl; int exrt; bit fl;
    int sa; int sta; int ha; int sb; int stb; int hb;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input int idv, input int rs, input int rt, input int urt,
                              input int jmp, input int hlt, input int exv, input int exl,
                              input int exrt, input int fl, input int sa, input int sta,
                              input int ha, input int sb, input int stb, input int hb);
    vec_t v;
    v.idv = idv[0]; v.rs = rs; v.rt = rt; v.urt = urt[0]; v.jmp = jmp[0]; v.hlt = hlt[0];
    v.exv = exv[0]; v.exl = exl[0]; v.exrt = exrt; v.fl = fl[0];
    v.sa = sa; v.sta = sta; v.ha = ha; v.sb = sb; v.stb = stb; v.hb = hb;
    return v;
  endfunction

  initial begin
    ll[0] = 1; js[0] = 1;
    ll[1] = 3; js[1] = 2;
    //              idv rs rt urt jmp hlt exv exl exrt fl | a: s st h | b: s st h
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // lw r5 in EX, add reads r5
    vecs[1]  = mk(1, 5, 0, 0, 0, 0, 1, 1, 5, 0,  1, 0, 0,  1, 0, 0);
    vecs[2]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // lw r7, consumer reads r7 through rt
    vecs[4]  = mk(1, 3, 7, 1, 0, 0, 1, 1, 7, 0,  1, 0, 0,  1, 0, 0);
    vecs[5]  = mk(1, 3, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0);
    vecs[6]  = mk(1, 3, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0);
    vecs[7]  = mk(1, 3, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // rt not read, then pending r7 read through rs
    vecs[8]  = mk(1, 1, 7, 0, 0, 0, 1, 1, 7, 0,  0, 0, 0,  0, 0, 0);
    vecs[9]  = mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // load to r0 is never a hazard
    vecs[11] = mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0,  0, 0, 0);
    vecs[12] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // branch held in ID
    vecs[13] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0,  1, 1, 0);
    vecs[15] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // halt, sticky, then flush
    vecs[18] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 1,  1, 2, 1);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 1,  1, 2, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 1,  1, 2, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // flush discards a load issued in the same cycle
    vecs[23] = mk(1, 9, 0, 0, 0, 0, 1, 1, 9, 1,  1, 0, 0,  1, 0, 0);
    vecs[24] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    // load hazard outranks a jump in ID
    vecs[25] = mk(1, 4, 0, 0, 1, 0, 1, 1, 4, 0,  1, 0, 0,  1, 0, 0);
    vecs[26] = mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0);
    vecs[27] = mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0,  1, 0, 0);
    vecs[28] = mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  0, 1, 0);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1, 0);
    vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset stall_a", int'(stall_a), 0);
    chk("reset state_a", int'(state_a), 0);
    chk("reset halt_b",  int'(halt_b),  0);
    chk("reset bubble_b", int'(bubble_b), 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < 32; i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.idv, v.rs, v.rt, v.urt, v.jmp, v.hlt, v.exv, v.exl, v.exrt, v.fl);
      #2;
      chk($sformatf("vec%0d stall_a", i),  int'(stall_a),  v.sa);
      chk($sformatf("vec%0d bubble_a", i), int'(bubble_a), v.sa);
      chk($sformatf("vec%0d state_a", i),  int'(state_a),  v.sta);
      chk($sformatf("vec%0d halt_a", i),   int'(halt_a),   v.ha);
      chk($sformatf("vec%0d stall_b", i),  int'(stall_b),  v.sb);
      chk($sformatf("vec%0d bubble_b", i), int'(bubble_b), v.sb);
      chk($sformatf("vec%0d state_b", i),  int'(state_b),  v.stb);
      chk($sformatf("vec%0d halt_b", i),   int'(halt_b),   v.hb);
      check_model($sformatf("vec%0d model", i));
      advance();
    end

    // reset while waiting out a jump with a long load pending
    drive(1, 1, 0, 0, 1, 0, 1, 1, 6, 0);
    #2;
    check_model("rstseq jump");
    advance();
    drive(1, 6, 0, 0, 0, 0, 1, 1, 6, 0);
    #1;
    chk("rstseq pre state_b", int'(state_b), 1);
    chk("rstseq pre stall_b", int'(stall_b), 1);
    i_rst_n = 1'b0;
    #1;
    chk("rstseq stall_a",  int'(stall_a),  0);
    chk("rstseq bubble_a", int'(bubble_a), 0);
    chk("rstseq state_a",  int'(state_a),  0);
    chk("rstseq stall_b",  int'(stall_b),  0);
    chk("rstseq bubble_b", int'(bubble_b), 0);
    chk("rstseq state_b",  int'(state_b),  0);
    chk("rstseq halt_b",   int'(halt_b),   0);
    @(posedge i_clk);
    #1;
    chk("rstseq held stall_b", int'(stall_b), 0);
    model_reset();
    i_rst_n = 1'b1;
    drive(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rstseq after stall_b", int'(stall_b), 0);
    chk("rstseq after state_b", int'(state_b), 0);
    check_model("rstseq after");
    advance();
    #2;
    check_model("rstseq after2");
    advance();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            $urandom_range(0, 24) == 0);
      #2;
      check_model($sformatf("rand%0d", n));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
